// File: rtl/fxp_pkg.sv
// Shared definitions for the fixed-point multiplier: saturation limits,
// overflow classification and the parameter-legality check.
package fxp_pkg;

    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_POS  = 2'd1,
        SAT_NEG  = 2'd2
    } sat_kind_e;

    // Largest value representable in a q_w-bit two's-complement word.
    function automatic logic signed [63:0] sat_max(input int unsigned q_w);
        return (64'sd1 <<< (q_w - 32'd1)) - 64'sd1;
    endfunction

    // Most negative value representable in a q_w-bit two's-complement word.
    function automatic logic signed [63:0] sat_min(input int unsigned q_w);
        return -(64'sd1 <<< (q_w - 32'd1));
    endfunction

    // True when the output window lies inside the product and the pipeline depth is supported.
    function automatic bit params_legal(input int a_w, input int b_w, input int q_w,
                                        input int shift, input int mult_stages, input int cnt_w);
        return (a_w > 0) && (b_w > 0) && (q_w > 0) && (q_w <= a_w + b_w) &&
               (shift >= 0) && (shift <= a_w + b_w - q_w) &&
               (mult_stages >= 1) && (mult_stages <= 4) && (cnt_w >= 1);
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational round (FXP_MULT_ROUND_EN), window selection and saturation
// of a full signed product down to Q_W bits.
module fxp_round_sat
    import fxp_pkg::*;
#(
    parameter int P_W   = 32,
    parameter int Q_W   = 16,
    parameter int SHIFT = 16
) (
    input  logic signed [P_W-1:0] p,
    output logic signed [Q_W-1:0] q,
    output logic                  ovf
);

    // One guard bit above the product absorbs the rounding carry.
    localparam int R_W    = P_W + 1;
    localparam int HI_POS = SHIFT + Q_W - 1;
    localparam logic [Q_W-1:0] Q_MAX = Q_W'(sat_max(Q_W));
    localparam logic [Q_W-1:0] Q_MIN = Q_W'(sat_min(Q_W));
`ifdef FXP_MULT_ROUND_EN
    // Half an output LSB; shifting right after the left shift makes SHIFT=0 a no-op.
    localparam logic [R_W-1:0] RND_K = ({{(R_W-1){1'b0}}, 1'b1} << SHIFT) >> 1;
`endif

    logic signed [R_W-1:0] pr_s;
    logic signed [R_W-1:0] hi_s;
    logic        [Q_W-1:0] win_s;
    sat_kind_e             kind_s;

    // Rounded/extended product, window extraction and overflow classification.
    always_comb begin
        pr_s = {p[P_W-1], p};
`ifdef FXP_MULT_ROUND_EN
        pr_s = pr_s + $signed(RND_K);
`endif
        win_s = pr_s[HI_POS:SHIFT];
        // Window MSB plus everything above it must be a pure sign extension.
        hi_s  = pr_s >>> HI_POS;
        if ((hi_s == '0) || (hi_s == '1)) begin
            kind_s = SAT_NONE;
        end else if (pr_s[R_W-1]) begin
            kind_s = SAT_NEG;
        end else begin
            kind_s = SAT_POS;
        end
    end

    // Saturated result selection.
    always_comb begin
        q   = win_s;
        ovf = 1'b0;
        case (kind_s)
            SAT_NONE: begin
                q   = win_s;
                ovf = 1'b0;
            end
            SAT_POS: begin
                q   = Q_MAX;
                ovf = 1'b1;
            end
            SAT_NEG: begin
                q   = Q_MIN;
                ovf = 1'b1;
            end
            default: begin
                q   = win_s;
                ovf = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fxp_mult_pipe.sv
// Pipelined signed fixed-point multiplier with valid/ready flow control,
// saturation and an overflow-event counter. Rounding enabled by FXP_MULT_ROUND_EN.
module fxp_mult_pipe
    import fxp_pkg::*;
#(
    parameter int A_W         = 16,
    parameter int B_W         = 16,
    parameter int Q_W         = 16,
    parameter int SHIFT       = 16,
    parameter int MULT_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [Q_W-1:0]   q,
    output logic                    q_ovf,
    input  logic                    ovf_clr,
    output logic        [CNT_W-1:0] ovf_cnt
);

    localparam int P_W  = A_W + B_W;
    localparam int LAST = MULT_STAGES - 1;
    localparam bit PARAMS_OK = params_legal(A_W, B_W, Q_W, SHIFT, MULT_STAGES, CNT_W);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    if (!PARAMS_OK) begin : g_param_err
        $error("fxp_mult_pipe: SHIFT/Q_W/MULT_STAGES out of legal range");
    end

    logic                  stall_s;
    logic signed [A_W-1:0] a_r;
    logic signed [B_W-1:0] b_r;
    logic                  v_in_r;
    logic signed [P_W-1:0] prod_s;
    logic signed [P_W-1:0] prod_r [MULT_STAGES];
    logic                  pv_r   [MULT_STAGES];
    logic signed [Q_W-1:0] rs_q_s;
    logic                  rs_ovf_s;
    logic                  out_valid_r;
    logic signed [Q_W-1:0] q_r;
    logic                  q_ovf_r;
    logic [CNT_W-1:0]      ovf_cnt_r;

    // The whole pipe freezes while a result waits at the output.
    assign stall_s  = out_valid_r & ~out_ready;
    assign in_ready = ~stall_s;

    // Input register: captures operands only on an accepted transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_in_r <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
        end else if (!stall_s) begin
            v_in_r <= in_valid;
            if (in_valid) begin
                a_r <= a;
                b_r <= b;
            end
        end
    end

    // Exact product; left inferred so synthesis can retime it through the product registers.
    assign prod_s = $signed({{B_W{a_r[A_W-1]}}, a_r}) * $signed({{A_W{b_r[B_W-1]}}, b_r});

    // Product pipeline with a valid bit per stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MULT_STAGES; i++) begin
                pv_r[i]   <= 1'b0;
                prod_r[i] <= '0;
            end
        end else if (!stall_s) begin
            pv_r[0]   <= v_in_r;
            prod_r[0] <= prod_s;
            for (int i = 1; i < MULT_STAGES; i++) begin
                pv_r[i]   <= pv_r[i-1];
                prod_r[i] <= prod_r[i-1];
            end
        end
    end

    fxp_round_sat #(
        .P_W   (P_W),
        .Q_W   (Q_W),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .p   (prod_r[LAST]),
        .q   (rs_q_s),
        .ovf (rs_ovf_s)
    );

    // Output register; result and flag hold across bubbles and stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            q_r         <= '0;
            q_ovf_r     <= 1'b0;
        end else if (!stall_s) begin
            out_valid_r <= pv_r[LAST];
            if (pv_r[LAST]) begin
                q_r     <= rs_q_s;
                q_ovf_r <= rs_ovf_s;
            end
        end
    end

    // Saturating count of delivered overflow results; clear wins over increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_cnt_r <= '0;
        end else if (ovf_clr) begin
            ovf_cnt_r <= '0;
        end else if (out_valid_r && out_ready && q_ovf_r && (ovf_cnt_r != '1)) begin
            ovf_cnt_r <= ovf_cnt_r + CNT_ONE;
        end
    end

    assign out_valid = out_valid_r;
    assign q         = q_r;
    assign q_ovf     = q_ovf_r;
    assign ovf_cnt   = ovf_cnt_r;

endmodule
